// File: rtl/srlatch_write_ctrl.sv
// Write sequencer for a bank of gated SR latches.
// Arbitrates round-robin between requesters and drives a registered
// SETUP -> PULSE -> HOLD waveform, then checks Q readback against the written bits.
module srlatch_write_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned NREQ         = 2,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic [NREQ*WIDTH-1:0] wmask,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  busy,
    output logic [WIDTH-1:0]      lat_S,
    output logic [WIDTH-1:0]      lat_R,
    output logic                  lat_C,
    input  logic [WIDTH-1:0]      lat_Q
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Counter reload values: a phase of N cycles counts N-1 down to 0
    localparam logic [7:0] SetupLd = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PulseLd = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] HoldLd  = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StCheck
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  lat_s_q, lat_s_d;
    logic [WIDTH-1:0]  lat_r_q, lat_r_d;
    logic              lat_c_q, lat_c_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;

    logic              win_vld;
    logic [PtrW-1:0]   win_idx;

    // Round-robin pick: lowest set request above the pointer, else wrap to the lowest overall
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && req[i] && (i > 32'(ptr_q))) begin
                win_vld = 1'b1;
                win_idx = PtrW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && req[i] && (i <= 32'(ptr_q))) begin
                win_vld = 1'b1;
                win_idx = PtrW'(i);
            end
        end
    end

    // Grant is only offered while idle, so a transfer always starts a fresh sequence
    always_comb begin
        gnt = '0;
        if ((state_q == StIdle) && win_vld) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Next-state, phase counter and capture of the granted request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        d_d     = d_q;
        m_d     = m_q;
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    state_d = StSetup;
                    cnt_d   = SetupLd;
                    d_d     = wdata[win_idx*WIDTH +: WIDTH];
                    m_d     = wmask[win_idx*WIDTH +: WIDTH];
                    owner_d = win_idx;
                    ptr_d   = win_idx;
                end
            end
            StSetup: begin
                if (cnt_q == 8'd0) begin
                    state_d = StPulse;
                    cnt_d   = PulseLd;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StPulse: begin
                if (cnt_q == 8'd0) begin
                    state_d = StHold;
                    cnt_d   = HoldLd;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StHold: begin
                if (cnt_q == 8'd0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCheck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Latch-side outputs derived from the next state so they are registered, not decoded
    always_comb begin
        lat_s_d = '0;
        lat_r_d = '0;
        lat_c_d = 1'b0;
        done_d  = '0;
        err_d   = 1'b0;
        // S and R come from complementary data under the same mask, so they never overlap
        if (state_d != StIdle) begin
            lat_s_d = d_d & m_d;
            lat_r_d = ~d_d & m_d;
        end
        if (state_d == StPulse) begin
            lat_c_d = 1'b1;
        end
        // Q is sampled at the end of HOLD, after the latch has closed
        if (state_d == StCheck) begin
            done_d[owner_d] = 1'b1;
            err_d           = |((lat_Q ^ d_q) & m_q);
        end
    end

    // All state and registered outputs; reset drops lat_C immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= PtrW'(NREQ - 1);
            owner_q <= '0;
            d_q     <= '0;
            m_q     <= '0;
            lat_s_q <= '0;
            lat_r_q <= '0;
            lat_c_q <= 1'b0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            d_q     <= d_d;
            m_q     <= m_d;
            lat_s_q <= lat_s_d;
            lat_r_q <= lat_r_d;
            lat_c_q <= lat_c_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign lat_S = lat_s_q;
    assign lat_R = lat_r_q;
    assign lat_C = lat_c_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_srlatch_write_ctrl.sv
// Directed bench for srlatch_write_ctrl with a behavioural gated SR latch bank.
module tb_srlatch_write_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] wdata;
    logic [15:0] wmask;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        busy;
    logic [7:0]  lat_S;
    logic [7:0]  lat_R;
    logic        lat_C;
    logic [7:0]  lat_Q;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural latch bank; stuck_mask forces selected Q bits to 0
    logic [7:0] lat_mem = 8'h00;
    logic [7:0] stuck_mask;

    always @(lat_C or lat_S or lat_R) begin
        if (lat_C) lat_mem = (lat_mem | lat_S) & ~lat_R;
    end
    assign lat_Q = lat_mem & ~stuck_mask;

    srlatch_write_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wdata (wdata),
        .wmask (wmask),
        .gnt   (gnt),
        .done  (done),
        .err   (err),
        .busy  (busy),
        .lat_S (lat_S),
        .lat_R (lat_R),
        .lat_C (lat_C),
        .lat_Q (lat_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Continuous invariants: S/R never overlap, grant zero or one-hot
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (((lat_S & lat_R) != 8'h00) || !$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL invariant: S&R=%0h gnt=%0b", lat_S & lat_R, gnt);
            end
        end
    end

    typedef struct {
        int         who;
        logic [7:0] d;
        logic [7:0] m;
        logic [7:0] exp_s;
        logic [7:0] exp_r;
        logic [7:0] exp_q;
        logic       exp_err;
        logic       stuck;
    } vec_t;

    vec_t tbl[5];

    // One full write, checked cycle by cycle from the grant cycle to the done cycle
    task automatic do_write(input int idx, input vec_t v);
        logic [1:0] oh;
        oh = 2'(1 << v.who);
        @(posedge clk);
        #1;
        stuck_mask = v.stuck ? 8'h08 : 8'h00;
        req = '0;
        req[v.who] = 1'b1;
        wdata[v.who*8 +: 8] = v.d;
        wmask[v.who*8 +: 8] = v.m;
        @(negedge clk);
        check($sformatf("v%0d gnt", idx), 32'(gnt), 32'(oh));
        check($sformatf("v%0d busy idle", idx), 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        req = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("v%0d k%0d lat_C", idx, k), 32'(lat_C), 32'((k == 1) || (k == 2)));
            check($sformatf("v%0d k%0d done", idx, k), 32'(done), (k == 4) ? 32'(oh) : 32'd0);
            check($sformatf("v%0d k%0d err", idx, k), 32'(err), (k == 4) ? 32'(v.exp_err) : 32'd0);
            check($sformatf("v%0d k%0d busy", idx, k), 32'(busy), 32'd1);
            if (k == 0 || k == 4) begin
                check($sformatf("v%0d k%0d lat_S", idx, k), 32'(lat_S), 32'(v.exp_s));
                check($sformatf("v%0d k%0d lat_R", idx, k), 32'(lat_R), 32'(v.exp_r));
            end
            if (k == 4) check($sformatf("v%0d lat_Q", idx), 32'(lat_Q), 32'(v.exp_q));
        end
    endtask

    initial begin
        logic [1:0] exp_oh;
        logic       seen;

        //            who  d      m      S      R      Q      err   stuck
        tbl[0] = '{0, 8'hA5, 8'hFF, 8'hA5, 8'h5A, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{1, 8'h00, 8'h0F, 8'h00, 8'h0F, 8'hA0, 1'b0, 1'b0};
        tbl[2] = '{1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA0, 1'b0, 1'b0};
        tbl[3] = '{0, 8'h08, 8'hFF, 8'h08, 8'hF7, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{1, 8'h08, 8'hF7, 8'h00, 8'hF7, 8'h00, 1'b0, 1'b1};

        rst_n = 1'b0;
        req = '0;
        wdata = '0;
        wmask = '0;
        stuck_mask = 8'h00;

        // Reset state
        #12;
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst lat_C", 32'(lat_C), 32'd0);
        check("rst lat_S", 32'(lat_S), 32'd0);
        check("rst lat_R", 32'(lat_R), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) do_write(i, tbl[i]);
        stuck_mask = 8'h00;

        // Both requesting continuously: strict alternation starting at 0
        @(posedge clk);
        #1;
        wdata = {8'hC3, 8'h3C};
        wmask = 16'hFFFF;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
            seen = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (gnt != 2'b00) begin
                    seen = 1'b1;
                    break;
                end
            end
            check($sformatf("rr%0d gnt seen", g), 32'(seen), 32'd1);
            check($sformatf("rr%0d gnt", g), 32'(gnt), 32'(exp_oh));
            seen = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (done != 2'b00) begin
                    seen = 1'b1;
                    break;
                end
            end
            check($sformatf("rr%0d done seen", g), 32'(seen), 32'd1);
            check($sformatf("rr%0d done", g), 32'(done), 32'(exp_oh));
            check($sformatf("rr%0d err", g), 32'(err), 32'd0);
            check($sformatf("rr%0d lat_Q", g), 32'(lat_Q), (g % 2 == 0) ? 32'h3C : 32'hC3);
        end
        @(posedge clk);
        #1;
        req = 2'b00;
        repeat (3) @(posedge clk);

        // Reset in the middle of PULSE: C must drop without a clock edge, no done
        #1;
        wdata[7:0] = 8'h5A;
        req = 2'b01;
        @(negedge clk);
        check("mid gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        #1;
        req = 2'b00;
        @(posedge clk);
        #2;
        check("mid lat_C high", 32'(lat_C), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid lat_C async", 32'(lat_C), 32'd0);
        check("mid busy", 32'(busy), 32'd0);
        check("mid lat_S", 32'(lat_S), 32'd0);
        check("mid lat_R", 32'(lat_R), 32'd0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check($sformatf("mid rst done%0d", t), 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check($sformatf("post rst done%0d", t), 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        req = 2'b11;
        @(negedge clk);
        check("post rst gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        #1;
        req = 2'b00;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        check("post rst done seen", 32'(seen), 32'd1);
        check("post rst done", 32'(done), 32'd1);
        check("post rst err", 32'(err), 32'd0);
        check("post rst lat_Q", 32'(lat_Q), 32'h5A);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
